// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
//   Master-mode SPI transfer sequencer. Accepts one transfer request while idle,
//   latches its configuration, generates SCK from a programmable divider, drives
//   NSS/MOSI, samples MISO and returns the received word with done/busy status.
//
// Ports
//   clk_i, rst_i        block clock, synchronous active-high reset
//   start_i, abort_i    transfer request (idle only) / abort of a running transfer
//   div_i               SCK half-period = div_i+1 clk_i cycles
//   dtb_i               transfer length N = 8*(dtb_i+1) bits
//   lsb_i               1: bit0 first, 0: bit N-1 first (TX and RX)
//   cpol_i, cpha_i      SCK idle level / sampling edge select
//   ass_i               1: NSS from nss_sel_i (latched), 0: NSS = ~nss_man_i (live)
//   nss_sel_i           automatic slave-select mask
//   nss_man_i           manual slave-select mask
//   tx_data_i           transmit word (low N bits used)
//   spi_miso_i          serial input
//   spi_sck_o           serial clock
//   spi_nss_o           slave selects, active low
//   spi_mosi_o          serial output
//   rx_data_o           received word, low N bits, upper bits zero
//   busy_o              high while a transfer is in progress
//   done_o              one-cycle completion pulse

module spi_xfer_ctrl #(
  parameter int unsigned NSS_NUM = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [7:0]         div_i,
  input  logic [1:0]         dtb_i,
  input  logic               lsb_i,
  input  logic               cpol_i,
  input  logic               cpha_i,
  input  logic               ass_i,
  input  logic [NSS_NUM-1:0] nss_sel_i,
  input  logic [NSS_NUM-1:0] nss_man_i,
  input  logic [31:0]        tx_data_i,
  input  logic               spi_miso_i,
  output logic               spi_sck_o,
  output logic [NSS_NUM-1:0] spi_nss_o,
  output logic               spi_mosi_o,
  output logic [31:0]        rx_data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 6;   // SCK edge counter, up to 2*32-1
  localparam int unsigned PW = 5;   // normalisation shift amount

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state;
  logic [7:0]         div_lat;
  logic [7:0]         div_cnt;
  logic [1:0]         dtb_lat;
  logic               lsb_lat;
  logic               cpol_lat;
  logic               cpha_lat;
  logic               ass_lat;
  logic [NSS_NUM-1:0] sel_lat;
  logic [DW-1:0]      tx_sh;
  logic [DW-1:0]      rx_sh;
  logic [EW-1:0]      edge_cnt;

  logic               tick_c;
  logic [EW-1:0]      last_edge_c;
  logic               leading_c;
  logic [PW-1:0]      tx_pad_c;
  logic [PW-1:0]      rx_pad_c;
  logic [DW-1:0]      tx_norm_c;
  logic [DW-1:0]      rx_norm_c;
  logic               tx_first_c;
  logic               tx_head_c;
  logic               tx_next_c;
  logic [DW-1:0]      tx_shift_c;
  logic [DW-1:0]      rx_shift_c;
  logic [NSS_NUM-1:0] nss_run_c;

  // Datapath helpers. The TX word is normalised so the first bit to send always
  // sits at bit 0 (LSB-first) or bit 31 (MSB-first), whatever the length.
  always_comb begin
    tick_c      = (div_cnt == div_lat);
    last_edge_c = EW'((32'(dtb_lat) + 32'd1) * 32'd16 - 32'd1);
    leading_c   = ~edge_cnt[0];
    tx_pad_c    = PW'((32'd3 - 32'(dtb_i)) * 32'd8);
    rx_pad_c    = PW'((32'd3 - 32'(dtb_lat)) * 32'd8);
    tx_norm_c   = lsb_i ? tx_data_i : (tx_data_i << tx_pad_c);
    tx_first_c  = lsb_i ? tx_norm_c[0] : tx_norm_c[DW-1];
    // LSB-first RX shifts in from the top, so realign the N bits down to bit 0.
    rx_norm_c   = lsb_lat ? (rx_sh >> rx_pad_c) : rx_sh;
    tx_head_c   = lsb_lat ? tx_sh[0] : tx_sh[DW-1];
    tx_next_c   = lsb_lat ? tx_sh[1] : tx_sh[DW-2];
    tx_shift_c  = lsb_lat ? (tx_sh >> 1) : (tx_sh << 1);
    rx_shift_c  = lsb_lat ? {spi_miso_i, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], spi_miso_i};
    nss_run_c   = ass_lat ? ~sel_lat : ~nss_man_i;
  end

  // Transfer sequencer: state, divider, shift registers and registered pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      div_lat    <= '0;
      div_cnt    <= '0;
      dtb_lat    <= '0;
      lsb_lat    <= 1'b0;
      cpol_lat   <= 1'b0;
      cpha_lat   <= 1'b0;
      ass_lat    <= 1'b0;
      sel_lat    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      edge_cnt   <= '0;
      spi_sck_o  <= 1'b0;
      spi_nss_o  <= '1;
      spi_mosi_o <= 1'b0;
      rx_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_nss_o <= ass_i ? '1 : ~nss_man_i;
          if (start_i) begin
            div_lat    <= div_i;
            dtb_lat    <= dtb_i;
            lsb_lat    <= lsb_i;
            cpol_lat   <= cpol_i;
            cpha_lat   <= cpha_i;
            ass_lat    <= ass_i;
            sel_lat    <= nss_sel_i;
            tx_sh      <= tx_norm_c;
            rx_sh      <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            spi_sck_o  <= cpol_i;
            spi_nss_o  <= ass_i ? ~nss_sel_i : ~nss_man_i;
            // cpha=0 presents the first bit before the first leading edge.
            spi_mosi_o <= cpha_i ? 1'b0 : tx_first_c;
            busy_o     <= 1'b1;
            state      <= ST_SETUP;
          end
        end

        default: begin
          if (abort_i) begin
            spi_sck_o  <= cpol_lat;
            spi_nss_o  <= '1;
            spi_mosi_o <= 1'b0;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            spi_nss_o <= nss_run_c;
            div_cnt   <= tick_c ? '0 : div_cnt + 8'd1;
            if (tick_c) begin
              case (state)
                ST_SETUP: state <= ST_XFER;

                ST_XFER: begin
                  spi_sck_o <= ~spi_sck_o;
                  edge_cnt  <= edge_cnt + EW'(1);
                  if (leading_c != cpha_lat) begin
                    rx_sh <= rx_shift_c;
                  end else if (cpha_lat) begin
                    // First leading edge drives the head bit; later ones advance.
                    if (edge_cnt == '0) begin
                      spi_mosi_o <= tx_head_c;
                    end else begin
                      spi_mosi_o <= tx_next_c;
                      tx_sh      <= tx_shift_c;
                    end
                  end else if (edge_cnt != last_edge_c) begin
                    spi_mosi_o <= tx_next_c;
                    tx_sh      <= tx_shift_c;
                  end
                  if (edge_cnt == last_edge_c) begin
                    state <= ST_HOLD;
                  end
                end

                ST_HOLD: begin
                  spi_nss_o <= ass_lat ? '1 : ~nss_man_i;
                  rx_data_o <= rx_norm_c;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
